// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and the
// odd-parity rule used by both receiver and transmitter.
package uart_pkg;

   localparam int unsigned OVERSAMPLE_DEFAULT = 16;
   localparam int unsigned DATA_BITS          = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } uart_rx_state_e;

   // Odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side signal bundle: oversample strobe, serial line and enable in,
// received byte, completion pulse, error flags and busy out.
interface uart_receiver_if;
   import uart_pkg::*;

   logic                 iTick;
   logic                 iRx;
   logic                 iEN;
   logic [DATA_BITS-1:0] odata;
   logic                 oValid;
   logic                 oParityErr;
   logic                 oFrameErr;
   logic                 oBusy;

   modport master (
      output iTick, iRx, iEN,
      input  odata, oValid, oParityErr, oFrameErr, oBusy
   );

   modport slave (
      input  iTick, iRx, iEN,
      output odata, oValid, oParityErr, oFrameErr, oBusy
   );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start edge.
module uart_rx_sync (
   input  logic iClk,
   input  logic iRst_n,
   input  logic iD,
   output logic oQ
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= iD;
         sync_q <= meta_q;
      end
   end

   assign oQ = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: 8 data bits LSB first, odd parity, one stop bit,
// with break handling and registered result/flags.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
   parameter int unsigned MID_SAMPLE = 7
) (
   input logic            iClk,
   input logic            iRst_n,
   uart_receiver_if.slave bus
);

   localparam int unsigned   CW       = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] CNT_MID  = CW'(MID_SAMPLE);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

   uart_rx_state_e       state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 par_q, par_d;
   logic                 valid_q, valid_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 rx_s;
   logic                 cnt_last;

   uart_rx_sync u_rx_sync (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iD     (bus.iRx),
      .oQ     (rx_s)
   );

   assign cnt_last = (cnt_q == CNT_LAST);

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         par_q   <= 1'b0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         par_q   <= par_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      par_d   = par_q;
      valid_d = 1'b0;
      perr_d  = perr_q;
      ferr_d  = ferr_q;

      if (bus.iTick) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.iEN && !rx_s) begin
                  state_d = ST_START;
                  cnt_d   = '0;
                  bit_d   = '0;
               end
            end
            ST_START: begin
               if (cnt_q == CNT_MID) begin
                  state_d = rx_s ? ST_IDLE : ST_DATA;
                  cnt_d   = '0;
                  bit_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_DATA: begin
               if (cnt_last) begin
                  shift_d[bit_q] = rx_s;
                  cnt_d          = '0;
                  bit_d          = bit_q + 1'b1;
                  if (bit_q == BIT_LAST) begin
                     state_d = ST_PARITY;
                     bit_d   = '0;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_PARITY: begin
               if (cnt_last) begin
                  par_d   = rx_s;
                  cnt_d   = '0;
                  state_d = ST_STOP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_STOP: begin
               // Result and flags are registered here so they appear with oValid.
               if (cnt_last) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  perr_d  = (par_q != odd_parity(shift_q));
                  ferr_d  = !rx_s;
                  cnt_d   = '0;
                  state_d = rx_s ? ST_IDLE : ST_BREAK;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_BREAK: begin
               if (rx_s) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               bit_d   = '0;
            end
         endcase
      end
   end

   assign bus.odata      = data_q;
   assign bus.oValid     = valid_q;
   assign bus.oParityErr = perr_q;
   assign bus.oFrameErr  = ferr_q;
   assign bus.oBusy      = (state_q != ST_IDLE);

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter OVERSAMPLE, default 16: iTick strobes per serial bit period.
REQ-002 Parameter MID_SAMPLE, default 7: tick index, from the falling edge, at which the start bit is confirmed.
REQ-003 iClk  input  1  sole clock, all state updates on rising edge.
REQ-004 iRst_n  input  1  reset, asynchronous, active-low.
REQ-005 iTick  input  1  oversample strobe, one iClk wide, OVERSAMPLE per bit.
REQ-006 iRx  input  1  serial line from transmitter, idle high, asynchronous to iClk.
REQ-007 iEN  input  1  receiver enable; 0 holds block in IDLE.
REQ-008 odata  output  8  last received data byte, held until next completed frame.
REQ-009 oValid  output  1  one-iClk pulse, frame complete, odata/error flags valid.
REQ-010 oParityErr  output  1  parity mismatch for the frame flagged by oValid, held until next oValid.
REQ-011 oFrameErr  output  1  stop bit sampled 0 for the frame flagged by oValid, held until next oValid.
REQ-012 oBusy  output  1  high in every state except IDLE.

Function
REQ-013 Frame: start 0, 8 data bits LSB first, parity bit, stop 1; odd parity, i.e. expected parity bit = NOT(XOR of data bits).
REQ-014 iRx passes a 2-flop synchronizer before any use; rx_s denotes its output (2 iClk latency).
REQ-015 States: IDLE, START, DATA, PARITY, STOP, BREAK; all counters advance only on iTick.
REQ-016 IDLE: on iTick with iEN=1 and rx_s=0 -> START, tick counter cleared to 0.
REQ-017 START: counter increments per tick; at counter==MID_SAMPLE, rx_s=0 -> DATA with counter cleared; rx_s=1 -> IDLE (false start, no oValid).
REQ-018 DATA: at counter==OVERSAMPLE-1 sample rx_s into shift register bit [bit_idx], counter wraps to 0, bit_idx increments; after bit_idx 7 sampled -> PARITY.
REQ-019 PARITY: at counter==OVERSAMPLE-1 sample parity bit, wrap counter -> STOP.
REQ-020 STOP: at counter==OVERSAMPLE-1 sample stop bit; next iClk: odata <= shift register, oValid=1, oParityErr and oFrameErr updated.
REQ-021 STOP with stop=1 -> IDLE; stop=0 -> BREAK.
REQ-022 BREAK: remain until iTick with rx_s=1, then IDLE; no start detection while in BREAK.
REQ-023 iEN deasserted mid-frame: current frame completes; IDLE does not leave while iEN=0.
REQ-024 Back-to-back frames: a start edge sampled on the first tick after returning to IDLE is accepted.
REQ-025 bit_idx 3 bits, tick counter width clog2(OVERSAMPLE); both clear on every state entry.

Reset
REQ-026 iRst_n low: state IDLE, counters 0, synchronizer flops 1, odata 8'h00, oValid 0, oParityErr 0, oFrameErr 0, oBusy 0, immediately, independent of iClk.
REQ-027 Reset asserted mid-frame discards the partial frame; no oValid is generated for it.

Structure
REQ-028 Shared package uart_pkg holds the state enumeration, OVERSAMPLE default, DATA_BITS=8 and the odd-parity rule, shared with the transmitter.
REQ-029 One sub-module, uart_rx_sync (2-flop synchronizer, reset to 1), instanced for iRx.

Verification
REQ-030 Frame 0xA5, parity 1, stop 1, 16 ticks/bit -> single oValid pulse, odata=0xA5, oParityErr=0, oFrameErr=0.
REQ-031 Frame 0x07 with parity 1 (expected 0) -> oValid, odata=0x07, oParityErr=1, oFrameErr=0.
REQ-032 iRx low for 4 ticks then high -> START aborts at tick 7, no oValid, oBusy returns 0.
REQ-033 Frame 0x3C with stop=0, line held low 40 ticks, then high, then frame 0x3C valid -> first oValid with oFrameErr=1, no start detected during the low hold, second oValid with odata=0x3C and both error flags 0.
REQ-034 iRst_n pulsed low during data bit 3 -> all outputs at reset values same cycle; following frame 0x81 received correctly.
REQ-035 Frames 0x00 then 0xFF with no idle gap -> two oValid pulses, odata 0x00 then 0xFF, no errors.
